// File: rtl/wb_arbiter_pkg.sv
// Shared types and sizing for the write-back arbiter: FU result payload,
// completion port and the source/port counts used by the core.
package wb_arbiter_pkg;

    localparam int TRANS_ID_BITS = 4;
    localparam int NR_WB_SRC     = 5;
    localparam int NR_WB_PORTS   = 3;
    localparam int WB_SRC_DEPTH  = 2;

    typedef logic [NR_WB_SRC-1:0] wb_src_bitvector_t;

    typedef struct packed {
        logic [TRANS_ID_BITS-1:0] id;
        logic [4:0]               rd;
        logic [31:0]              data;
    } fu_output_t;

    typedef struct packed {
        logic                     valid;
        logic [TRANS_ID_BITS-1:0] id;
    } completion_port_t;

    // Single-step modulo; callers guarantee idx < 2*n.
    function automatic int wrap_idx(input int idx, input int n);
        return (idx >= n) ? idx - n : idx;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source circular result buffer. Flush wins over push and pop; a push
// while full is ignored (the arbiter never issues one).
module wb_src_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WB_SRC_DEPTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  fu_output_t data_in,
    output fu_output_t data_out,
    output logic       full,
    output logic       empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    fu_output_t       mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign data_out = mem[head];

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + PTR_W'(1);
            if (do_pop)  head <= head + PTR_W'(1);
            if (do_push && !do_pop)      count <= count + CNT_W'(1);
            else if (do_pop && !do_push) count <= count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[tail] <= data_in;
    end

    a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && full));
    a_count_bound:  assert property (@(posedge clk) disable iff (rst) count <= CNT_W'(DEPTH));

endmodule

// File: rtl/wb_arbiter.sv
// Merges buffered FU results onto NR_OUT write-back ports with round-robin
// priority; outputs come straight from the buffer heads.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NR_SRC = NR_WB_SRC,
    parameter int NR_OUT = NR_WB_PORTS,
    parameter int DEPTH  = WB_SRC_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  fu_output_t       src_i       [NR_SRC],
    input  logic [NR_SRC-1:0] src_valid_i,
    output logic [NR_SRC-1:0] src_ready_o,
    input  logic             squash_i,
    output fu_output_t       wb_o        [NR_OUT],
    output logic [NR_OUT-1:0] wb_valid_o,
    output completion_port_t compl_o     [NR_OUT]
);

    localparam int SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;

    logic [NR_SRC-1:0] full;
    logic [NR_SRC-1:0] empty;
    logic [NR_SRC-1:0] push;
    logic [NR_SRC-1:0] pop;
    logic [NR_SRC-1:0] taken;
    fu_output_t        head_data [NR_SRC];
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  rr_next;
    logic [SRC_W-1:0]  idx;
    logic [SRC_W-1:0]  port_src  [NR_OUT];
    logic [NR_OUT-1:0] port_vld;

    assign src_ready_o = ~full & {NR_SRC{~rst}};
    assign push        = src_valid_i & src_ready_o;

    for (genvar s = 0; s < NR_SRC; s++) begin : g_src
        wb_src_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .push     (push[s]),
            .pop      (pop[s]),
            .flush    (squash_i),
            .data_in  (src_i[s]),
            .data_out (head_data[s]),
            .full     (full[s]),
            .empty    (empty[s])
        );
    end

    // Each port takes the first not-yet-taken non-empty source in scan
    // order starting at rr_ptr, which yields the first NR_OUT in order.
    always_comb begin
        taken    = '0;
        port_vld = '0;
        idx      = '0;
        rr_next  = rr_ptr;
        for (int p = 0; p < NR_OUT; p++) port_src[p] = '0;
        for (int p = 0; p < NR_OUT; p++) begin
            for (int i = 0; i < NR_SRC; i++) begin
                idx = SRC_W'(wrap_idx(int'(rr_ptr) + i, NR_SRC));
                if (!port_vld[p] && !empty[idx] && !taken[idx]) begin
                    port_vld[p] = 1'b1;
                    port_src[p] = idx;
                    taken[idx]  = 1'b1;
                end
            end
            if (port_vld[p]) rr_next = SRC_W'(wrap_idx(int'(port_src[p]) + 1, NR_SRC));
        end
        pop = taken;
        if (squash_i) begin
            pop      = '0;
            port_vld = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           rr_ptr <= '0;
        else if (squash_i) rr_ptr <= '0;
        else               rr_ptr <= rr_next;
    end

    always_comb begin
        wb_valid_o = port_vld;
        for (int p = 0; p < NR_OUT; p++) begin
            wb_o[p]          = port_vld[p] ? head_data[port_src[p]] : '0;
            compl_o[p].valid = port_vld[p];
            compl_o[p].id    = wb_o[p].id;
        end
    end

    for (genvar p = 0; p < NR_OUT; p++) begin : g_uniq
        for (genvar q = p + 1; q < NR_OUT; q++) begin : g_pair
            a_distinct_src: assert property (@(posedge clk) disable iff (rst)
                !(port_vld[p] && port_vld[q] && port_src[p] == port_src[q]));
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios on the 3-port build, a per-source
// FIFO-order scoreboard, and a round-robin fairness run on a 1-port build.
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NS   = 5;
    localparam int NO   = 3;
    localparam int FU_W = $bits(fu_output_t);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---------------- DUT (3 ports) ----------------
    fu_output_t       src_i [NS];
    logic [NS-1:0]    src_valid_i;
    logic [NS-1:0]    src_ready_o;
    logic             squash_i;
    fu_output_t       wb_o [NO];
    logic [NO-1:0]    wb_valid_o;
    completion_port_t compl_o [NO];
    logic [NO-1:0]    compl_vld;

    wb_arbiter dut (
        .clk         (clk),
        .rst         (rst),
        .src_i       (src_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .squash_i    (squash_i),
        .wb_o        (wb_o),
        .wb_valid_o  (wb_valid_o),
        .compl_o     (compl_o)
    );

    always_comb for (int p = 0; p < NO; p++) compl_vld[p] = compl_o[p].valid;

    // ---------------- DUT (1 port) for fairness ----------------
    fu_output_t       f_src [NS];
    logic [NS-1:0]    f_valid;
    logic [NS-1:0]    f_ready;
    logic             f_squash;
    fu_output_t       f_wb [1];
    logic [0:0]       f_wb_valid;
    completion_port_t f_compl [1];

    wb_arbiter #(.NR_OUT(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .src_i       (f_src),
        .src_valid_i (f_valid),
        .src_ready_o (f_ready),
        .squash_i    (f_squash),
        .wb_o        (f_wb),
        .wb_valid_o  (f_wb_valid),
        .compl_o     (f_compl)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic fu_output_t make_res(input int s, input int seq);
        fu_output_t r;
        r.id   = TRANS_ID_BITS'(s + seq * NS);
        r.rd   = 5'(s);
        r.data = {8'(s), 24'(seq)};
        return r;
    endfunction

    // ---------------- scoreboard ----------------
    // Source index lives in data[31:24]; the oldest entry of that source must
    // be the one presented.
    logic [FU_W-1:0] exp_q[$];
    bit              mon_found;

    always @(negedge clk) begin
        if (!rst) begin
            for (int p = 0; p < NO; p++) begin
                if (wb_valid_o[p]) begin
                    mon_found = 1'b0;
                    for (int k = 0; k < exp_q.size(); k++) begin
                        if (!mon_found && exp_q[k][31:24] == wb_o[p].data[31:24]) begin
                            mon_found = 1'b1;
                            check("wb_payload", wb_o[p], exp_q[k]);
                            check("compl_id", compl_o[p].id, exp_q[k][FU_W-1 -: TRANS_ID_BITS]);
                            exp_q.delete(k);
                        end
                    end
                    if (!mon_found) check("wb_orphan", 1, 0);
                end
            end
            if (squash_i) exp_q.delete();
            else for (int s = 0; s < NS; s++)
                if (src_valid_i[s] && src_ready_o[s]) exp_q.push_back(src_i[s]);
        end
    end

    // ---------------- driver ----------------
    int remaining [NS];
    int seq       [NS];

    task automatic apply_drive();
        for (int s = 0; s < NS; s++) begin
            src_valid_i[s] = (remaining[s] > 0);
            src_i[s]       = make_res(s, seq[s]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sources hold their payload until accepted, then move to the next one.
    task automatic drive_cycles(input int n);
        logic [NS-1:0] acc;
        repeat (n) begin
            @(negedge clk);
            acc = src_valid_i & src_ready_o & ~{NS{squash_i}};
            step();
            for (int s = 0; s < NS; s++)
                if (acc[s]) begin
                    remaining[s]--;
                    seq[s]++;
                end
            apply_drive();
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        fu_output_t r;
        int left;
        rst         = 1'b1;
        squash_i    = 1'b0;
        f_squash    = 1'b0;
        f_valid     = '0;
        src_valid_i = '1;
        for (int s = 0; s < NS; s++) begin
            src_i[s]     = make_res(s, 9);
            f_src[s]     = make_res(s, 0);
            remaining[s] = 0;
            seq[s]       = 0;
        end

        // reset with sources offering
        repeat (3) begin
            @(negedge clk);
            check("rst_wb_valid", wb_valid_o, 0);
            check("rst_ready", src_ready_o, 0);
            check("rst_compl_valid", compl_vld, 0);
        end
        step();
        rst         = 1'b0;
        src_valid_i = '0;
        @(negedge clk);
        check("post_rst_ready", src_ready_o, 5'b11111);
        check("post_rst_no_fill", wb_valid_o, 0);

        // single-source latency
        repeat (8) step();
        r    = make_res(0, 0);
        r.id = 4'd7;
        src_i[0]    = r;
        src_valid_i = 5'b00001;
        @(negedge clk);
        check("lat_same_cycle", wb_valid_o, 0);
        step();
        src_valid_i = '0;
        @(negedge clk);
        check("lat_valid", wb_valid_o, 3'b001);
        check("lat_wb_id", wb_o[0].id, 7);
        check("lat_compl_id", compl_o[0].id, 7);
        check("lat_compl_valid", compl_vld, 3'b001);
        step();
        @(negedge clk);
        check("lat_after", wb_valid_o, 0);

        // squash while idle returns rr_ptr to 0
        step();
        squash_i = 1'b1;
        step();
        squash_i = 1'b0;

        // oversubscription: ids 0..4 pushed together
        remaining = '{1, 1, 1, 1, 1};
        apply_drive();
        drive_cycles(1);
        @(negedge clk);
        check("over1_valid", wb_valid_o, 3'b111);
        check("over1_id0", wb_o[0].id, 0);
        check("over1_id1", wb_o[1].id, 1);
        check("over1_id2", wb_o[2].id, 2);
        step();
        @(negedge clk);
        check("over2_valid", wb_valid_o, 3'b011);
        check("over2_id3", wb_o[0].id, 3);
        check("over2_id4", wb_o[1].id, 4);
        step();
        @(negedge clk);
        check("over3_idle", wb_valid_o, 0);
        step();

        // backpressure: source 4 fills while 0-3 keep all ports busy
        remaining = '{4, 4, 4, 4, 3};
        apply_drive();
        drive_cycles(2);
        @(negedge clk);
        check("bp_src4_not_ready", src_ready_o[4], 0);
        check("bp_grant_src4", wb_o[1].rd, 4);
        drive_cycles(40);
        left = 0;
        for (int s = 0; s < NS; s++) left += remaining[s];
        check("bp_all_accepted", left, 0);
        check("bp_sb_drained", exp_q.size(), 0);

        // squash mid-flight with a concurrent push
        remaining = '{1, 1, 1, 1, 0};
        apply_drive();
        drive_cycles(1);
        squash_i       = 1'b1;
        src_valid_i[4] = 1'b1;
        src_i[4]       = make_res(4, 50);
        @(negedge clk);
        check("sq_wb_valid", wb_valid_o, 0);
        check("sq_compl_valid", compl_vld, 0);
        step();
        squash_i    = 1'b0;
        src_valid_i = '0;
        @(negedge clk);
        check("sq_flushed", wb_valid_o, 0);
        src_i[0]    = make_res(0, 60);
        src_i[4]    = make_res(4, 60);
        src_valid_i = 5'b10001;
        step();
        src_valid_i = '0;
        @(negedge clk);
        check("sq_rr_valid", wb_valid_o, 3'b011);
        check("sq_rr_port0", wb_o[0].rd, 0);
        check("sq_rr_port1", wb_o[1].rd, 4);
        step();

        // fairness on the 1-port build
        f_valid = 5'b01001;
        step();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("fair_valid", f_wb_valid, 1'b1);
            check("fair_src", f_wb[0].rd, (k % 2 == 0) ? 0 : 3);
            step();
        end
        f_valid = '0;

        check("sb_final_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Sits directly downstream of the functional-unit cluster. Merges per-FU result streams (fu_output_t) onto a smaller set of register-file write-back ports, and drives the matching completion ports.
- Each source has a small buffer, so FUs with latency > 1 can present results without the write-back port stalling them.
- Round-robin arbitration grants up to NR_OUT buffered results per cycle.
- A squash flushes every buffered, not-yet-written result.

Parameters:
- NR_SRC, 5: number of FU result sources (ALU, CSR/misc, LSU, DIV, MUL).
- NR_OUT, 3: number of write-back ports produced; must satisfy 1 <= NR_OUT <= NR_SRC.
- DEPTH, 2: entries per source buffer; power of two, >= 2.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- src_i  in  NR_SRC x $bits(fu_output_t)  per-source result (id, rd, data, ...).
- src_valid_i  in  NR_SRC  result offered by source.
- src_ready_o  out  NR_SRC  source buffer can accept.
- squash_i  in  1  flush all buffered results.
- wb_o  out  NR_OUT x $bits(fu_output_t)  write-back port payload.
- wb_valid_o  out  NR_OUT  write-back port valid; the consumer always accepts.
- compl_o  out  NR_OUT x $bits(completion_port_t)  completion port (id copied from wb_o, valid = wb_valid_o).

Behaviour:
- Reset (async, rst=1):
  - All buffers are empty.
  - rr_ptr = 0.
  - wb_valid_o = 0, compl_o.valid = 0.
  - src_ready_o = all ones once rst is released; src_ready_o = 0 while rst=1.
  - wb_o payload is don't-care but driven '0.
- Per-source buffer:
  - Circular FIFO of DEPTH entries with head, tail and count (count width $clog2(DEPTH)+1).
  - src_ready_o[s] = (count < DEPTH). There is no same-cycle full bypass: a full buffer that is popped this cycle still shows ready=0.
  - Push on src_valid_i[s] & src_ready_o[s].
  - Simultaneous push and pop keep count unchanged. Pointers wrap modulo DEPTH.
  - If a source drives valid while not ready, the source holds its data (standard valid/ready).
- Latency: a result accepted in cycle N appears on wb_o no earlier than cycle N+1. Outputs come combinationally from the buffer heads; there is no output register.
- Arbitration (combinational, each cycle):
  - Scan sources starting at rr_ptr, wrapping modulo NR_SRC.
  - The first NR_OUT non-empty sources are granted, in scan order, to wb ports 0..NR_OUT-1.
  - Ungranted ports have wb_valid_o=0.
  - Granted buffers pop at the clock edge.
- Pointer update: if at least one grant occurs, rr_ptr <= (index of last granted source + 1) mod NR_SRC. Otherwise rr_ptr holds.
- Ordering: results from one source leave in FIFO order. There is no ordering guarantee across sources.
- Squash (squash_i=1):
  - wb_valid_o and compl_o.valid are forced to 0 in that cycle.
  - All counts/head/tail are cleared at the edge.
  - Pushes in the same cycle are dropped.
  - rr_ptr is reset to 0.
  - src_ready_o is unaffected in the squash cycle.
- Simultaneous events on a full source: pop plus an attempted push from that source gives no push (ready was 0); count becomes DEPTH-1.
- Assertions:
  - No two wb ports carry the same source in one cycle.
  - count never exceeds DEPTH.
  - No push occurs when full.

Decomposition:
- Package C gains:
  - NR_WB_SRC (replaces hard-coded FU-to-port mapping).
  - WB_SRC_DEPTH.
  - typedef wb_src_bitvector_t (logic [NR_WB_SRC-1:0]).
- fu_output_t and completion_port_t are reused unchanged.
- One sub-module, wb_src_fifo: parameterised DEPTH, payload type fu_output_t, with push/pop/flush and full/empty. It is instantiated NR_SRC times. Arbitration and rr_ptr live in wb_arbiter.

Test Plan:
- Reset:
  - Stimulus: hold rst 3 cycles with src_valid_i=5'b11111.
  - Required: wb_valid_o=0, src_ready_o=0, no buffer fill; after release, src_ready_o=5'b11111.
- Single-source latency:
  - Stimulus: ALU pushes id=7 at cycle 10.
  - Required: wb_o[0].id=7, wb_valid_o=3'b001 and compl_o[0].id=7 at cycle 11; nothing at cycle 12.
- Oversubscription:
  - Stimulus: all 5 sources push one result at cycle 0 (ids 0..4), rr_ptr=0.
  - Required:
    - Cycle 1 grants ids 0,1,2 and rr_ptr becomes 3.
    - Cycle 2 grants ids 3,4 and wb_valid_o=3'b011.
- Backpressure/full:
  - Stimulus: source 4 pushes 3 consecutive cycles while sources 0-3 saturate all ports.
  - Required: src_ready_o[4]=0 after 2 pushes; the third result is held by the source; source 4 results emerge in order once its turn comes.
- Squash mid-flight:
  - Stimulus: 4 results buffered, then squash_i=1 together with a new push.
  - Required: wb_valid_o=0 in the squash cycle; next cycle all buffers are empty, the new push is lost and rr_ptr=0.
- Fairness:
  - Stimulus: sources 0 and 3 continuously valid, NR_OUT=1 build.
  - Required: grants alternate 0,3,0,3; neither source goes two cycles without a grant.
